// File: rtl/mod_mul_iter.sv
// Interleaved modular multiplier S = A*B mod N, one multiplier bit per clock, MSB first.
// Valid/ready on both sides, squaring mode, operand range check with err, synchronous abort.
module mod_mul_iter #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] N,
    input  logic             sq,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             err
);
    localparam int CW = $clog2(WIDTH);
    localparam int TW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, CAL, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, b_q, n_q, c_q, c_nx;
    logic [CW-1:0]    idx_q;
    logic             accept, bad, last;
    logic [TW-1:0]    t, n1, n2, t_red;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & (state == IDLE) & ~abort;
    assign bad       = (N == '0) | (A >= N) | (~sq & (B >= N));
    assign last      = (idx_q == '0);

    // T < 3N always fits in WIDTH+2 bits, so at most two subtractions restore C < N
    assign t  = {1'b0, c_q, 1'b0} + {2'b00, (b_q[idx_q] ? a_q : {WIDTH{1'b0}})};
    assign n1 = {2'b00, n_q};
    assign n2 = {1'b0, n_q, 1'b0};

    always_comb begin
        t_red = t;
        if (t >= n2)      t_red = t - n2;
        else if (t >= n1) t_red = t - n1;
    end
    assign c_nx = t_red[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = bad ? DONE : CAL;
            CAL:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= '0;
            c_q   <= '0;
            idx_q <= '0;
            S     <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= sq ? A : B;
            n_q   <= N;
            c_q   <= '0;
            idx_q <= CW'(WIDTH - 1);
            if (bad) begin
                S   <= '0;
                err <= 1'b1;
            end
        end else if (state == CAL && !abort) begin
            c_q   <= c_nx;
            idx_q <= idx_q - 1'b1;
            if (last) begin
                S   <= c_nx;
                err <= 1'b0;
            end
        end
    end
endmodule
